// File: rtl/dmem_loader.sv
// dmem_loader: fills data_mem from an external byte stream while the CPU is held.
// Every four stream bytes are packed little-endian into one word and written to
// consecutive word addresses starting at BASE_ADDR (the address wraps).
// Optional build macro LOADER_VERIFY_EN: after every write the word is read back
// over two cycles and compared; a mismatch sets the sticky error flag.
module dmem_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_enable,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] w_address,
  output logic [DATA_W-1:0] w_data,
  output logic              w_enable,
  output logic [ADDR_W-1:0] r_address,
  input  logic [DATA_W-1:0] o_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DONE    = 3'd3
`ifdef LOADER_VERIFY_EN
    ,
    ST_VERIFY  = 3'd4
`endif
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W:0]     len_r, len_s;
  logic [ADDR_W:0]     word_cnt_r, word_cnt_s;
  logic [1:0]          byte_cnt_r, byte_cnt_s;
  logic [DATA_W-1:0]   word_r, word_s;
  logic [ADDR_W-1:0]   w_address_r, w_address_s;
  logic [DATA_W-1:0]   w_data_r, w_data_s;
  logic                cpu_hold_r, cpu_hold_s;
  logic                done_r, done_s;
  logic                s_ready_s;
  logic                w_enable_s;
`ifdef LOADER_VERIFY_EN
  logic [ADDR_W-1:0]   r_address_r, r_address_s;
  logic                error_r, error_s;
  logic                vphase_r, vphase_s;
`else
  logic                unused_o_data_s;
`endif

  // Next-state and next-register computation; everything holds while clk_enable is low.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    word_cnt_s  = word_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    word_s      = word_r;
    w_address_s = w_address_r;
    w_data_s    = w_data_r;
    cpu_hold_s  = cpu_hold_r;
    done_s      = done_r;
    s_ready_s   = 1'b0;
    w_enable_s  = 1'b0;
`ifdef LOADER_VERIFY_EN
    r_address_s = r_address_r;
    error_s     = error_r;
    vphase_s    = vphase_r;
`endif
    if (clk_enable) begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_s      = len;
            word_cnt_s = LEN_ZERO;
            byte_cnt_s = 2'd0;
            done_s     = 1'b0;
            cpu_hold_s = 1'b1;
`ifdef LOADER_VERIFY_EN
            error_s    = 1'b0;
`endif
            if (len == LEN_ZERO) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_COLLECT;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          s_ready_s = 1'b1;
          if (s_valid) begin
            word_s[{byte_cnt_r, 3'b000} +: 8] = s_data;
            if (byte_cnt_r == 2'd3) begin
              byte_cnt_s  = 2'd0;
              w_address_s = BASE_ADDR + word_cnt_r[ADDR_W-1:0];
              w_data_s    = word_s;
              state_s     = ST_WRITE;
            end else begin
              byte_cnt_s = byte_cnt_r + 2'd1;
            end
          end else begin
            state_s = ST_COLLECT;
          end
        end
        ST_WRITE: begin
          w_enable_s = 1'b1;
          word_cnt_s = word_cnt_r + CNT_ONE;
`ifdef LOADER_VERIFY_EN
          r_address_s = w_address_r;
          vphase_s    = 1'b0;
          state_s     = ST_VERIFY;
`else
          if (word_cnt_s == len_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_COLLECT;
          end
`endif
        end
`ifdef LOADER_VERIFY_EN
        ST_VERIFY: begin
          // First cycle presents the address; read data is valid on the second.
          if (!vphase_r) begin
            vphase_s = 1'b1;
          end else begin
            if (o_data != w_data_r) begin
              error_s = 1'b1;
            end else begin
              error_s = error_r;
            end
            r_address_s = {ADDR_W{1'b0}};
            if (word_cnt_r == len_r) begin
              state_s = ST_DONE;
            end else begin
              state_s = ST_COLLECT;
            end
          end
        end
`endif
        ST_DONE: begin
          cpu_hold_s = 1'b0;
          done_s     = 1'b1;
          state_s    = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      len_r       <= LEN_ZERO;
      word_cnt_r  <= LEN_ZERO;
      byte_cnt_r  <= 2'd0;
      word_r      <= {DATA_W{1'b0}};
      w_address_r <= {ADDR_W{1'b0}};
      w_data_r    <= {DATA_W{1'b0}};
      cpu_hold_r  <= 1'b0;
      done_r      <= 1'b0;
`ifdef LOADER_VERIFY_EN
      r_address_r <= {ADDR_W{1'b0}};
      error_r     <= 1'b0;
      vphase_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      len_r       <= len_s;
      word_cnt_r  <= word_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      word_r      <= word_s;
      w_address_r <= w_address_s;
      w_data_r    <= w_data_s;
      cpu_hold_r  <= cpu_hold_s;
      done_r      <= done_s;
`ifdef LOADER_VERIFY_EN
      r_address_r <= r_address_s;
      error_r     <= error_s;
      vphase_r    <= vphase_s;
`endif
    end
  end

  assign s_ready   = s_ready_s;
  assign w_enable  = w_enable_s;
  assign w_address = w_address_r;
  assign w_data    = w_data_r;
  assign cpu_hold  = cpu_hold_r;
  assign done      = done_r;
`ifdef LOADER_VERIFY_EN
  assign r_address = r_address_r;
  assign error     = error_r;
`else
  assign r_address       = {ADDR_W{1'b0}};
  assign error           = 1'b0;
  assign unused_o_data_s = ^o_data;
`endif

endmodule

// File: tb/tb_dmem_loader.sv
// tb_dmem_loader: two loaders (BASE_ADDR 0 and 254) fed with identical stimulus,
// each writing into its own memory model; results compared against a reference
// model computed from the byte stream.
`timescale 1ns/1ps
module tb_dmem_loader;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NA = 256;
  localparam int BASE_B = 254;
`ifdef LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, clk_enable, start, s_valid;
  logic [AW:0]   len;
  logic [7:0]    s_data;
  logic          s_ready_a, w_enable_a, cpu_hold_a, done_a, error_a;
  logic          s_ready_b, w_enable_b, cpu_hold_b, done_b, error_b;
  logic [AW-1:0] w_address_a, r_address_a, w_address_b, r_address_b;
  logic [DW-1:0] w_data_a, o_data_a, w_data_b, o_data_b;

  logic [DW-1:0] mem_a [NA];
  logic [DW-1:0] mem_b [NA];
  int            wcnt_a [NA];
  int            wcnt_b [NA];
  logic          mem_clr;
  logic          corrupt;

  logic [7:0]    bq [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  dmem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(8'd0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .w_address(w_address_a), .w_data(w_data_a), .w_enable(w_enable_a),
    .r_address(r_address_a), .o_data(o_data_a),
    .cpu_hold(cpu_hold_a), .done(done_a), .error(error_a)
  );

  dmem_loader #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(8'd254)) dut_b (
    .clk(clk), .rst_n(rst_n), .clk_enable(clk_enable), .start(start), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .w_address(w_address_b), .w_data(w_data_b), .w_enable(w_enable_b),
    .r_address(r_address_b), .o_data(o_data_b),
    .cpu_hold(cpu_hold_b), .done(done_b), .error(error_b)
  );

  // data_mem models: synchronous write, registered read; memory A can flip bit 0 at address 1.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < NA; i++) begin
        wcnt_a[i] <= 0;
        wcnt_b[i] <= 0;
      end
    end else begin
      if (w_enable_a) begin
        mem_a[w_address_a]  <= w_data_a ^ ((corrupt && w_address_a == 8'd1) ? 32'd1 : 32'd0);
        wcnt_a[w_address_a] <= wcnt_a[w_address_a] + 1;
      end
      if (w_enable_b) begin
        mem_b[w_address_b]  <= w_data_b;
        wcnt_b[w_address_b] <= wcnt_b[w_address_b] + 1;
      end
    end
    o_data_a <= mem_a[r_address_a];
    o_data_b <= mem_b[r_address_b];
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
  endfunction

  // One load: start, stream bq with random gaps, optional clk_enable stall and busy start.
  task automatic run_load(input int L, input int gap_pct, input int stall_at,
                          input int busy_at, input int abort_bytes,
                          output bit aborted, output int wr_a_o);
    int ptr = 0, nb, wr_a = 0, wr_b = 0, last_w = 0, done_cyc = 0, hold_bad = 0, gate_bad = 0;
    int budget;
    nb      = L * 4;
    budget  = 20 * L + 40;
    aborted = 1'b0;
    @(negedge clk); mem_clr = 1'b1;
    @(negedge clk); mem_clr = 1'b0;
    start = 1'b1; len = L[AW:0]; s_valid = 1'b0; clk_enable = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start      = (cyc == busy_at);
      if (cyc == busy_at) len = 9'd7;
      clk_enable = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3);
      s_valid    = (ptr < nb) && ($urandom_range(99) >= gap_pct);
      s_data     = (ptr < nb) ? bq[ptr] : 8'h00;
      #1;
      if (!clk_enable && (s_ready_a || w_enable_a || s_ready_b || w_enable_b)) gate_bad++;
      if (s_valid && s_ready_a) ptr++;
      if (w_enable_a) begin wr_a++; last_w = cyc; end
      if (w_enable_b) wr_b++;
      if (done_a) begin done_cyc = cyc; break; end
      if (!cpu_hold_a || !cpu_hold_b) hold_bad++;
      if (abort_bytes > 0 && ptr == abort_bytes) begin aborted = 1'b1; break; end
    end
    wr_a_o = wr_a;
    if (!aborted) begin
      int bad_cnt = 0, bad_mem = 0, gap;
      start = 1'b0; s_valid = 1'b0;
      check("done reached", done_cyc > 0, 1);
      gap = (L == 0) ? 2 : last_w + (VERIFY ? 4 : 2);
      check("done timing", done_cyc, gap);
      check("done B", done_b, 1);
      check("hold released", {cpu_hold_a, cpu_hold_b}, 2'b00);
      check("hold during load", hold_bad, 0);
      check("clk_enable gating", gate_bad, 0);
      check("bytes consumed", ptr, nb);
      check("write count B", wr_b, L);
      check("error A", error_a, VERIFY && corrupt && L >= 2);
      check("error B", error_b, 0);
      for (int a = 0; a < NA; a++) begin
        int off_b;
        off_b = (a - BASE_B + NA) % NA;
        if (wcnt_a[a] != ((a < L) ? 1 : 0)) bad_cnt++;
        if (wcnt_b[a] != ((off_b < L) ? 1 : 0)) bad_cnt++;
        if (a < L && mem_a[a] !== (exp_word(a) ^ ((corrupt && a == 1) ? 32'd1 : 32'd0))) bad_mem++;
        if (off_b < L && mem_b[a] !== exp_word(off_b)) bad_mem++;
      end
      check("write map", bad_cnt, 0);
      check("memory contents", bad_mem, 0);
      @(negedge clk); #1;
      check("done level", {done_a, cpu_hold_a}, 2'b10);
    end
  endtask

  typedef struct {
    int len;
    int gap_pct;
    int stall_at;
    int busy_at;
    int exp_writes;
  } vec_t;

  vec_t tbl [7];
  bit   ab;
  int   wr;
  logic [31:0] w0_saved;

  initial begin
    tbl[0] = '{len: 2,   gap_pct: 0,  stall_at: 0, busy_at: 0,  exp_writes: 2};
    tbl[1] = '{len: 3,   gap_pct: 40, stall_at: 3, busy_at: 0,  exp_writes: 3};
    tbl[2] = '{len: 5,   gap_pct: 30, stall_at: 2, busy_at: 4,  exp_writes: 5};
    tbl[3] = '{len: 0,   gap_pct: 0,  stall_at: 0, busy_at: 1,  exp_writes: 0};
    tbl[4] = '{len: 1,   gap_pct: 60, stall_at: 0, busy_at: 0,  exp_writes: 1};
    tbl[5] = '{len: 256, gap_pct: 10, stall_at: 4, busy_at: 20, exp_writes: 256};
    tbl[6] = '{len: 3,   gap_pct: 0,  stall_at: 0, busy_at: 0,  exp_writes: 3};

    rst_n = 1'b0; clk_enable = 1'b1; start = 1'b0; len = '0;
    s_valid = 1'b0; s_data = 8'h00; mem_clr = 1'b0; corrupt = VERIFY;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("reset strobes", {s_ready_a, w_enable_a, cpu_hold_a, done_a, error_a}, 5'b0);
    check("reset addr/data", {w_address_a, r_address_a, w_data_a}, 48'h0);

    for (int t = 0; t < 7; t++) begin
      bq.delete();
      for (int k = 0; k < 4 * tbl[t].len; k++) begin
        if (t == 0) bq.push_back(8'(8'h11 * (k + 1)));
        else        bq.push_back(8'($urandom_range(255)));
      end
      run_load(tbl[t].len, tbl[t].gap_pct, tbl[t].stall_at, tbl[t].busy_at, 0, ab, wr);
      check("write count A", wr, tbl[t].exp_writes);
      if (t == 0) begin
        check("mem_a[0]", mem_a[0], 32'h44332211);
        check("mem_a[1]", mem_a[1], 32'h88776655 ^ (VERIFY ? 32'd1 : 32'd0));
        check("mem_b[254]", mem_b[254], 32'h44332211);
        check("mem_b[255]", mem_b[255], 32'h88776655);
      end
    end

    // Reset after two bytes of word 1, then a clean reload.
    bq.delete();
    for (int k = 0; k < 8; k++) bq.push_back(8'($urandom_range(255)));
    w0_saved = exp_word(0);
    run_load(2, 20, 0, 0, 6, ab, wr);
    check("abort reached", ab, 1);
    @(negedge clk); rst_n = 1'b0; s_valid = 1'b0; start = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    check("abort state", {cpu_hold_a, done_a, s_ready_a, w_enable_a, cpu_hold_b}, 5'b0);
    check("abort mem_a[0]", mem_a[0], w0_saved);
    check("abort writes", {wcnt_a[0], wcnt_a[1]}, {32'd1, 32'd0});
    bq.delete();
    for (int k = 0; k < 8; k++) bq.push_back(8'($urandom_range(255)));
    run_load(2, 0, 0, 0, 0, ab, wr);
    check("reload write count", wr, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
